// File: rtl/i2s_pkg.sv
// i2s_pkg: shared frame geometry, counter widths and a saturating increment helper
package i2s_pkg;
  localparam int FRAME_SLOTS = 32;
  localparam int SAMPLE_W = 16;
  localparam int STEREO_W = 2 * SAMPLE_W;
  localparam int SLOT_W = $clog2(FRAME_SLOTS);
  localparam int CNT_W = 16;
  localparam int DIV_W = 8;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: bit clock divider, word select and slot counter with rise/fall event strobes
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              enable,
  output logic              bclk,
  output logic              lrclk,
  output logic              rise,
  output logic              fall,
  output logic [SLOT_W-1:0] slot
);
  logic [DIV_W-1:0] div_cnt;
  logic [SLOT_W-1:0] slot_nx;
  logic tc;
  assign tc = enable && (div_cnt == DIV_W'(BCLK_DIV - 1));
  assign rise = tc && !bclk;
  assign fall = tc && bclk;
  assign slot_nx = slot + 1'b1;
  // divider and bus clocks; parking at slot 31 makes the first fall after enable start slot 0
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      div_cnt <= '0;
      bclk <= 1'b0;
      lrclk <= 1'b1;
      slot <= '1;
    end else if (!enable) begin
      div_cnt <= '0;
      bclk <= 1'b0;
      lrclk <= 1'b1;
      slot <= '1;
    end else begin
      div_cnt <= tc ? '0 : div_cnt + 1'b1;
      if (tc) bclk <= !bclk;
      if (fall) begin
        slot <= slot_nx;
        lrclk <= slot_nx[SLOT_W-1];
      end
    end
  end
endmodule

// File: rtl/i2s_master_axis.sv
// i2s_master_axis: I2S bus master bridging AXI-Stream playback and record words to a codec
module i2s_master_axis
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 16
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                enable,
  output logic                audio_bclk,
  output logic                audio_lrclk,
  output logic                audio_dac,
  input  logic                audio_adc,
  input  logic [STEREO_W-1:0] from_host_audio_tdata,
  input  logic                from_host_audio_tvalid,
  output logic                from_host_audio_tready,
  output logic [STEREO_W-1:0] to_host_audio_tdata,
  output logic                to_host_audio_tvalid,
  input  logic                to_host_audio_tready,
  output logic [CNT_W-1:0]    underrun_count,
  output logic [CNT_W-1:0]    overrun_count
);
  logic rise, fall, adc_q, primed, frame_start, done;
  logic [SLOT_W-1:0] slot;
  logic [STEREO_W-1:0] tx_shreg, rx_word;
  logic [STEREO_W-2:0] rx_shreg;
  i2s_clkgen #(.BCLK_DIV(BCLK_DIV)) u_clkgen (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .enable  (enable),
    .bclk    (audio_bclk),
    .lrclk   (audio_lrclk),
    .rise    (rise),
    .fall    (fall),
    .slot    (slot)
  );
  assign frame_start = fall && (slot == SLOT_W'(FRAME_SLOTS - 1));
  assign done = rise && (slot == '0);
  assign from_host_audio_tready = frame_start && from_host_audio_tvalid;
  assign rx_word = {rx_shreg, adc_q};
  // serializer: MSB leaves one bclk after the frame edge, so slot 0 carries the previous word's LSB
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tx_shreg <= '0;
      audio_dac <= 1'b0;
      underrun_count <= '0;
    end else if (!enable) begin
      tx_shreg <= '0;
      audio_dac <= 1'b0;
    end else if (fall) begin
      audio_dac <= tx_shreg[STEREO_W-1];
      tx_shreg <= !frame_start ? tx_shreg << 1 : from_host_audio_tvalid ? from_host_audio_tdata : '0;
      if (frame_start && !from_host_audio_tvalid) underrun_count <= sat_inc(underrun_count);
    end
  end
  // deserializer and record stream; the first completion after a restart is a partial frame
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      adc_q <= 1'b0;
      rx_shreg <= '0;
      primed <= 1'b0;
      to_host_audio_tdata <= '0;
      to_host_audio_tvalid <= 1'b0;
      overrun_count <= '0;
    end else begin
      adc_q <= audio_adc;
      if (!enable) begin
        rx_shreg <= '0;
        primed <= 1'b0;
      end else if (rise) begin
        rx_shreg <= rx_word[STEREO_W-2:0];
        if (done) primed <= 1'b1;
      end
      if (done && primed && (!to_host_audio_tvalid || to_host_audio_tready)) begin
        to_host_audio_tdata <= rx_word;
        to_host_audio_tvalid <= 1'b1;
      end else begin
        if (done && primed) overrun_count <= sat_inc(overrun_count);
        if (to_host_audio_tvalid && to_host_audio_tready) to_host_audio_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_i2s_master_axis.sv
// tb_i2s_master_axis: loopback bench with a cycle-count model of the I2S frame and AXIS handshakes
module tb_i2s_master_axis;
  localparam int D = 4;
  localparam int BP = 2 * D;
  localparam int FR = 64 * D;
  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic enable = 1'b0;
  logic audio_bclk, audio_lrclk, audio_dac, audio_adc;
  logic [31:0] from_host_audio_tdata = '0;
  logic from_host_audio_tvalid = 1'b0;
  logic from_host_audio_tready;
  logic [31:0] to_host_audio_tdata;
  logic to_host_audio_tvalid;
  logic to_host_audio_tready = 1'b1;
  logic [15:0] underrun_count, overrun_count;
  int pass_cnt = 0;
  int total_cnt = 0;
  bit started = 0;
  int n = 0;
  logic [31:0] words[$];
  logic mv = 1'b0;
  logic [31:0] mdata = '0;
  logic [15:0] mund = '0;
  logic [15:0] movr = '0;

  i2s_master_axis #(.BCLK_DIV(D)) dut (
    .ap_clk                (ap_clk),
    .ap_rst_n              (ap_rst_n),
    .enable                (enable),
    .audio_bclk            (audio_bclk),
    .audio_lrclk           (audio_lrclk),
    .audio_dac             (audio_dac),
    .audio_adc             (audio_adc),
    .from_host_audio_tdata (from_host_audio_tdata),
    .from_host_audio_tvalid(from_host_audio_tvalid),
    .from_host_audio_tready(from_host_audio_tready),
    .to_host_audio_tdata   (to_host_audio_tdata),
    .to_host_audio_tvalid  (to_host_audio_tvalid),
    .to_host_audio_tready  (to_host_audio_tready),
    .underrun_count        (underrun_count),
    .overrun_count         (overrun_count)
  );

  // codec loopback: the record stream is the playback stream
  assign audio_adc = audio_dac;

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // model: n counts enabled clock edges since (re)start; frames are 64*D edges, offset by one bclk
  always @(posedge ap_clk or negedge ap_rst_n) begin : mdl
    int e;
    bit comp;
    logic [31:0] w;
    comp = 0;
    w = '0;
    if (!ap_rst_n) begin
      n = 0;
      words.delete();
      mv = 0;
      mdata = '0;
      mund = '0;
      movr = '0;
    end else begin
      if (!enable) begin
        n = 0;
        words.delete();
      end else begin
        e = n + 1;
        if (e % FR == BP) begin
          words.push_back(from_host_audio_tvalid ? from_host_audio_tdata : 32'h0);
          if (!from_host_audio_tvalid && mund != 16'hFFFF) mund++;
        end
        if (e % FR == BP + D && e > FR) begin
          comp = 1;
          w = words[(e - BP - D) / FR - 1];
        end
        n = e;
      end
      if (comp) begin
        if (!mv || to_host_audio_tready) begin
          mdata = w;
          mv = 1;
        end else if (movr != 16'hFFFF) movr++;
      end else if (mv && to_host_audio_tready) mv = 0;
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge ap_clk) begin : cmp
    int k, s, f;
    logic ed, et;
    logic [31:0] w;
    if (started) begin
      k = n / BP;
      s = (k + 31) % 32;
      f = (k - 1) / 32;
      ed = 1'b0;
      if (k > 0) begin
        if (s == 0) begin
          if (f > 0) begin
            w = words[f-1];
            ed = w[0];
          end
        end else begin
          w = words[f];
          ed = w[32-s];
        end
      end
      et = ap_rst_n && enable && from_host_audio_tvalid && ((n + 1) % FR == BP);
      check("cycle", {audio_bclk, audio_lrclk, audio_dac, from_host_audio_tready, to_host_audio_tvalid,
                      to_host_audio_tdata, underrun_count, overrun_count},
            {1'((n / D) % 2), 1'(s >= 16), ed, et, mv, mdata, mund, movr});
    end
  end

  function automatic logic sig(input int sel);
    return sel == 0 ? audio_bclk : sel == 1 ? audio_lrclk : from_host_audio_tready;
  endfunction

  // cycles between rising edges (bclk, tready) or between toggles (lrclk)
  task automatic measure(input int sel, output int cyc);
    logic prev, cur;
    bit seen;
    int c;
    cyc = -1;
    seen = 0;
    c = 0;
    prev = sig(sel);
    for (int i = 0; i < 3000; i++) begin
      @(negedge ap_clk);
      cur = sig(sel);
      c++;
      if ((cur && !prev) || (sel == 1 && cur != prev)) begin
        if (seen) begin
          cyc = c;
          break;
        end
        seen = 1;
        c = 0;
      end
      prev = cur;
    end
  endtask

  // returns just after the clock edge that starts a new frame
  task automatic wait_frame();
    bit found;
    found = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge ap_clk);
      if (from_host_audio_tready) begin
        found = 1;
        break;
      end
    end
    check("frame_wait", found, 1);
    @(posedge ap_clk);
    #1;
  endtask

  task automatic first_tvalid(input string name);
    int c;
    c = -1;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge ap_clk);
      #1;
      if (to_host_audio_tvalid) begin
        c = i;
        break;
      end
    end
    check(name, c, FR + 3 * D);
  endtask

  initial begin
    int c;
    repeat (3) @(posedge ap_clk);
    #1;
    started = 1;
    check("rst_bclk", audio_bclk, 0);
    check("rst_lrclk", audio_lrclk, 1);
    check("rst_tvalid", to_host_audio_tvalid, 0);
    ap_rst_n = 1;
    enable = 1;
    from_host_audio_tvalid = 1;
    from_host_audio_tdata = 32'hA5A5_3C3C;
    measure(0, c);
    check("bclk_period", c, 8);
    measure(1, c);
    check("lrclk_half", c, 128);
    measure(2, c);
    check("tready_period", c, 256);
    check("loop_word", to_host_audio_tdata, 32'hA5A5_3C3C);
    c = 0;
    for (int i = 0; i < FR; i++) begin
      @(negedge ap_clk);
      if (to_host_audio_tvalid) c++;
    end
    check("tvalid_per_frame", c, 1);
    wait_frame();
    to_host_audio_tready = 0;
    from_host_audio_tdata = 32'h1234_8001;
    repeat (3 * FR + 3) @(posedge ap_clk);
    #1;
    check("ovr_held_valid", to_host_audio_tvalid, 1);
    check("ovr_held_word", to_host_audio_tdata, 32'hA5A5_3C3C);
    check("ovr_count", overrun_count, 2);
    to_host_audio_tready = 1;
    @(posedge ap_clk);
    #1;
    check("ovr_new_word", to_host_audio_tdata, 32'h1234_8001);
    check("ovr_new_valid", to_host_audio_tvalid, 1);
    check("ovr_unchanged", overrun_count, 2);
    wait_frame();
    from_host_audio_tvalid = 0;
    repeat (2 * FR) @(posedge ap_clk);
    #1;
    from_host_audio_tvalid = 1;
    check("und_count", underrun_count, 2);
    wait_frame();
    repeat (10 * BP + 2) @(posedge ap_clk);
    #1;
    enable = 0;
    @(posedge ap_clk);
    #1;
    check("gap_bclk", audio_bclk, 0);
    check("gap_lrclk", audio_lrclk, 1);
    repeat (49) @(posedge ap_clk);
    #1;
    check("gap_bclk_end", audio_bclk, 0);
    check("gap_lrclk_end", audio_lrclk, 1);
    check("gap_und", underrun_count, 2);
    check("gap_ovr", overrun_count, 2);
    check("gap_tvalid", to_host_audio_tvalid, 0);
    enable = 1;
    first_tvalid("restart_first_word");
    wait_frame();
    repeat (20 * BP + 2) @(posedge ap_clk);
    #1;
    ap_rst_n = 0;
    #1;
    check("rst_mid_out", {audio_bclk, audio_lrclk, audio_dac, from_host_audio_tready, to_host_audio_tvalid},
          5'b01000);
    check("rst_mid_tdata", to_host_audio_tdata, 0);
    check("rst_mid_cnt", {underrun_count, overrun_count}, 0);
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst_n = 1;
    first_tvalid("reset_first_word");
    repeat (10) @(posedge ap_clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
